// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters (fetch F,
// loader L) and the single-port synchronous-read memory.
//
// Handshake: a requester holds *_req (with stable address/data) until *_gnt is seen
// high in the same cycle; the response arrives exactly one cycle after the grant as
// a one-cycle *_rvalid pulse with no backpressure, so the requester must accept it.
interface imem_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;

    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_err;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction memory between the
// core fetch port (read-only) and the loader/debug port (read/write).
module imem_port_arbiter #(
    parameter int MEM_BYTES   = 1024,
    parameter bit FETCH_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    imem_port_arbiter_if.slave   bus,
    output logic                 dbg_fetch_pri
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    // Priority state: which side wins the next conflict.
    typedef enum logic {
        PRI_F = 1'b0,
        PRI_L = 1'b1
    } pri_e;

    typedef enum logic [1:0] {
        RSP_READ  = 2'd0,
        RSP_WRITE = 2'd1,
        RSP_ERROR = 2'd2
    } rsp_kind_e;

    pri_e        pri_q, pri_d;
    logic        grant_f, grant_l, grant_any;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic        legal;

    logic        rsp_valid_q;
    logic        rsp_owner_l_q;
    rsp_kind_e   rsp_kind_q;
    logic        rsp_live;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pri_q         <= FETCH_FIRST ? PRI_F : PRI_L;
            rsp_valid_q   <= 1'b0;
            rsp_owner_l_q <= 1'b0;
            rsp_kind_q    <= RSP_READ;
        end else begin
            pri_q         <= pri_d;
            rsp_valid_q   <= grant_any;
            rsp_owner_l_q <= grant_l;
            rsp_kind_q    <= !legal ? RSP_ERROR : (sel_we ? RSP_WRITE : RSP_READ);
        end
    end

    // Grants are gated by resetn so every output reads 0 while reset is held.
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        pri_d   = pri_q;
        if (resetn) begin
            if (bus.f_req && bus.l_req) begin
                if (pri_q == PRI_F) begin
                    grant_f = 1'b1;
                    pri_d   = PRI_L;
                end else begin
                    grant_l = 1'b1;
                    pri_d   = PRI_F;
                end
            end else if (bus.f_req) begin
                grant_f = 1'b1;
            end else if (bus.l_req) begin
                grant_l = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any = grant_f | grant_l;
        sel_addr  = grant_l ? bus.l_addr : bus.f_addr;
        sel_we    = grant_l & bus.l_we;
        legal     = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);

        bus.f_gnt     = grant_f;
        bus.l_gnt     = grant_l;
        bus.mem_en    = grant_any & legal;
        bus.mem_we    = grant_any & legal & sel_we;
        bus.mem_addr  = (grant_any && legal) ? sel_addr : 32'h0;
        bus.mem_wdata = (grant_any && legal && sel_we) ? bus.l_wdata : 32'h0;
    end

    // A reset asserted in the response cycle suppresses the pending response.
    always_comb begin
        rsp_live     = rsp_valid_q & resetn;
        bus.f_rvalid = rsp_live & ~rsp_owner_l_q;
        bus.l_rvalid = rsp_live & rsp_owner_l_q;
        bus.f_err    = bus.f_rvalid & (rsp_kind_q == RSP_ERROR);
        bus.l_err    = bus.l_rvalid & (rsp_kind_q == RSP_ERROR);
        bus.f_rdata  = (bus.f_rvalid && rsp_kind_q == RSP_READ) ? bus.mem_rdata : 32'h0;
        bus.l_rdata  = (bus.l_rvalid && rsp_kind_q == RSP_READ) ? bus.mem_rdata : 32'h0;
    end

    assign dbg_fetch_pri = (pri_q == PRI_F);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, an alternation sequence and
// randomized traffic checked against a byte-array reference of the memory system.
module tb_imem_port_arbiter;

    localparam int MEM_BYTES   = 1024;
    localparam bit FETCH_FIRST = 1'b1;
    localparam int AW          = $clog2(MEM_BYTES);
    localparam int RW          = 68;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic dbg_fetch_pri;

    imem_port_arbiter_if bus();

    imem_port_arbiter #(
        .MEM_BYTES   (MEM_BYTES),
        .FETCH_FIRST (FETCH_FIRST)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus),
        .dbg_fetch_pri (dbg_fetch_pri)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:MEM_BYTES/4-1];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tb_mem[bus.mem_addr[AW-1:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= tb_mem[bus.mem_addr[AW-1:2]];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]    ref_bytes [0:MEM_BYTES-1];
    int            last_winner;
    logic [RW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_fail = 0;

    logic          m_fgnt, m_lgnt, m_en, m_we;
    logic [31:0]   m_addr, m_wd;
    logic [RW-1:0] m_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // who: 0 = F, 1 = L; last_winner starts on the side that must lose the first conflict.
    task automatic model_step(input logic rst, fr, input logic [31:0] fa,
                              input logic lr, lwe, input logic [31:0] la, lwd);
        int          who;
        logic [31:0] a;
        logic        wr, ok;
        logic [31:0] rd;
        m_rsp  = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        m_fgnt = 1'b0; m_lgnt = 1'b0; m_en = 1'b0; m_we = 1'b0;
        m_addr = 32'h0; m_wd = 32'h0;
        if (!rst) begin
            m_rsp = '0;
            exp_q.delete();
            exp_q.push_back('0);
            last_winner = FETCH_FIRST ? 1 : 0;
            return;
        end
        if (fr && lr) begin
            who = 1 - last_winner;
            last_winner = who;
        end else if (fr) who = 0;
        else if (lr)     who = 1;
        else             who = -1;
        if (who < 0) begin
            exp_q.push_back('0);
            return;
        end
        a  = (who == 1) ? la : fa;
        wr = (who == 1) && lwe;
        ok = (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
        rd = 32'h0;
        if (who == 0) m_fgnt = 1'b1; else m_lgnt = 1'b1;
        if (ok) begin
            m_en = 1'b1; m_we = wr; m_addr = a;
            if (wr) begin
                m_wd = lwd;
                for (int k = 0; k < 4; k++) ref_bytes[int'(a) + k] = lwd[31 - 8*k -: 8];
            end else begin
                for (int k = 0; k < 4; k++) rd[31 - 8*k -: 8] = ref_bytes[int'(a) + k];
            end
        end
        if (who == 0) exp_q.push_back({1'b1, !ok, rd, 1'b0, 1'b0, 32'h0});
        else          exp_q.push_back({1'b0, 1'b0, 32'h0, 1'b1, !ok, rd});
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic rst, fr, input logic [31:0] fa,
                         input logic lr, lwe, input logic [31:0] la, lwd);
        @(posedge clk);
        #1;
        resetn = rst;
        bus.f_req = fr; bus.f_addr = fa;
        bus.l_req = lr; bus.l_we = lwe; bus.l_addr = la; bus.l_wdata = lwd;
        @(negedge clk);
        model_step(rst, fr, fa, lr, lwe, la, lwd);
        check("m_f_gnt",     {31'h0, bus.f_gnt},    {31'h0, m_fgnt});
        check("m_l_gnt",     {31'h0, bus.l_gnt},    {31'h0, m_lgnt});
        check("m_mem_en",    {31'h0, bus.mem_en},   {31'h0, m_en});
        check("m_mem_we",    {31'h0, bus.mem_we},   {31'h0, m_we});
        check("m_mem_addr",  bus.mem_addr,          m_addr);
        check("m_mem_wdata", bus.mem_wdata,         m_wd);
        check("m_f_rvalid",  {31'h0, bus.f_rvalid}, {31'h0, m_rsp[67]});
        check("m_f_err",     {31'h0, bus.f_err},    {31'h0, m_rsp[66]});
        check("m_f_rdata",   bus.f_rdata,           m_rsp[65:34]);
        check("m_l_rvalid",  {31'h0, bus.l_rvalid}, {31'h0, m_rsp[33]});
        check("m_l_err",     {31'h0, bus.l_err},    {31'h0, m_rsp[32]});
        check("m_l_rdata",   bus.l_rdata,           m_rsp[31:0]);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, fr;
        logic [31:0] fa;
        logic        lr, lwe;
        logic [31:0] la, lwd;
        logic [1:0]  gnt;
        logic        en, we;
        logic [31:0] addr, wd;
        logic        frv, ferr;
        logic [31:0] frd;
        logic        lrv, lerr;
        logic [31:0] lrd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, fr, logic [31:0] fa, logic lr, lwe,
                                logic [31:0] la, lwd, logic [1:0] gnt, logic en, we,
                                logic [31:0] addr, wd, logic frv, ferr, logic [31:0] frd,
                                logic lrv, lerr, logic [31:0] lrd);
        vec_t v;
        v.rst = rst; v.fr = fr; v.fa = fa; v.lr = lr; v.lwe = lwe; v.la = la; v.lwd = lwd;
        v.gnt = gnt; v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.frv = frv; v.ferr = ferr; v.frd = frd; v.lrv = lrv; v.lerr = lerr; v.lrd = lrd;
        return v;
    endfunction

    task automatic check_row(input int i, input vec_t v);
        string t;
        t = $sformatf("row%0d", i);
        check({t, "_f_gnt"},     {31'h0, bus.f_gnt},    {31'h0, v.gnt[1]});
        check({t, "_l_gnt"},     {31'h0, bus.l_gnt},    {31'h0, v.gnt[0]});
        check({t, "_mem_en"},    {31'h0, bus.mem_en},   {31'h0, v.en});
        check({t, "_mem_we"},    {31'h0, bus.mem_we},   {31'h0, v.we});
        check({t, "_mem_addr"},  bus.mem_addr,          v.addr);
        check({t, "_mem_wdata"}, bus.mem_wdata,         v.wd);
        check({t, "_f_rvalid"},  {31'h0, bus.f_rvalid}, {31'h0, v.frv});
        check({t, "_f_err"},     {31'h0, bus.f_err},    {31'h0, v.ferr});
        check({t, "_f_rdata"},   bus.f_rdata,           v.frd);
        check({t, "_l_rvalid"},  {31'h0, bus.l_rvalid}, {31'h0, v.lrv});
        check({t, "_l_err"},     {31'h0, bus.l_err},    {31'h0, v.lerr});
        check({t, "_l_rdata"},   bus.l_rdata,           v.lrd);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: rand_addr = 32'($urandom_range(0, 15)) * 4;
            6:                rand_addr = 32'($urandom_range(0, MEM_BYTES/4 - 1)) * 4;
            7:                rand_addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            8:                rand_addr = 32'(MEM_BYTES) + 32'($urandom_range(0, 3)) * 4;
            default:          rand_addr = $urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'(MEM_BYTES - 4);
        endcase
    endfunction

    initial begin
        bus.f_req = 1'b0; bus.f_addr = 32'h0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;
        for (int i = 0; i < MEM_BYTES/4; i++) tb_mem[i] = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) ref_bytes[i] = 8'h0;
        last_winner = FETCH_FIRST ? 1 : 0;

        //              rst fr fa      lr lwe la      lwd           gnt en we addr   wd           frv fe frd          lrv le lrd
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h10, 0, 0, 32'h0,   32'h0,        2'b10, 1, 0, 32'h10,  32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 1, 32'h4,   32'h00F00093, 2'b01, 1, 1, 32'h4,   32'h00F00093, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h4,  0, 0, 32'h0,   32'h0,        2'b10, 1, 0, 32'h4,   32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 32'h0,   32'h0,        1, 0, 32'h00F00093, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 1, 32'h8,   32'hAAAA0008, 2'b01, 1, 1, 32'h8,   32'hAAAA0008, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 1, 32'hC,   32'hBBBB000C, 2'b01, 1, 1, 32'hC,   32'hBBBB000C, 0, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h8,  1, 0, 32'hC,   32'h0,        2'b10, 1, 0, 32'h8,   32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h8,  1, 0, 32'hC,   32'h0,        2'b01, 1, 0, 32'hC,   32'h0,        1, 0, 32'hAAAA0008, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h8,  1, 0, 32'hC,   32'h0,        2'b10, 1, 0, 32'h8,   32'h0,        0, 0, 32'h0,        1, 0, 32'hBBBB000C));
        tbl.push_back(mk(1, 1, 32'h8,  1, 0, 32'hC,   32'h0,        2'b01, 1, 0, 32'hC,   32'h0,        1, 0, 32'hAAAA0008, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h8,  1, 0, 32'hC,   32'h0,        2'b10, 1, 0, 32'h8,   32'h0,        0, 0, 32'h0,        1, 0, 32'hBBBB000C));
        tbl.push_back(mk(1, 1, 32'h8,  1, 0, 32'hC,   32'h0,        2'b01, 1, 0, 32'hC,   32'h0,        1, 0, 32'hAAAA0008, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h6,  0, 0, 32'h0,   32'h0,        2'b10, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 0, 32'hBBBB000C));
        tbl.push_back(mk(1, 0, 32'h0,  1, 1, 32'h3FC, 32'hCAFEF00D, 2'b01, 1, 1, 32'h3FC, 32'hCAFEF00D, 1, 1, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0, 32'h3FC, 32'h0,        2'b01, 1, 0, 32'h3FC, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0, 32'h400, 32'h0,        2'b01, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 0, 32'hCAFEF00D));
        tbl.push_back(mk(1, 1, 32'h20, 0, 0, 32'h0,   32'h0,        2'b10, 1, 0, 32'h20,  32'h0,        0, 0, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h24, 1, 0, 32'h28,  32'h0,        2'b10, 1, 0, 32'h24,  32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0, 32'h8,   32'h0,        2'b01, 1, 0, 32'h8,   32'h0,        1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h24, 1, 0, 32'hC,   32'h0,        2'b01, 1, 0, 32'hC,   32'h0,        0, 0, 32'h0,        1, 0, 32'hAAAA0008));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        2'b00, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 0, 32'hBBBB000C));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].fr, tbl[i].fa, tbl[i].lr, tbl[i].lwe, tbl[i].la, tbl[i].lwd);
            check_row(i, tbl[i]);
        end

        // Continuous conflict straight after reset: F, L, F, L, ...
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0);
            check($sformatf("alt%0d_f_gnt", i), {31'h0, bus.f_gnt}, {31'h0, (i % 2 == 0)});
            check($sformatf("alt%0d_l_gnt", i), {31'h0, bus.l_gnt}, {31'h0, (i % 2 == 1)});
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 49) != 0,
                  $urandom_range(0, 2) != 0, rand_addr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
        end
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
